// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS encodings: opcodes, functs, ALU codes, aluop, controller states
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    // True for every opcode the controller knows how to sequence
    function automatic logic op_known(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// rtl/mc_aludec.sv - aluop/funct to ALU control decode with funct legality flag
module mc_aludec
    import mips_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alucontrol,
    output logic       o_funct_legal
);

    logic [2:0] w_funct_ctl;

    // Funct lookup; unknown functs fall back to add and are flagged
    always_comb begin
        w_funct_ctl   = ALU_ADD;
        o_funct_legal = 1'b1;
        case (i_funct)
            FUNCT_ADD: w_funct_ctl = ALU_ADD;
            FUNCT_SUB: w_funct_ctl = ALU_SUB;
            FUNCT_AND: w_funct_ctl = ALU_AND;
            FUNCT_OR:  w_funct_ctl = ALU_OR;
            FUNCT_SLT: w_funct_ctl = ALU_SLT;
            default: begin
                w_funct_ctl   = ALU_ADD;
                o_funct_legal = 1'b0;
            end
        endcase
    end

    // Select between fixed add/subtract and the funct-driven operation
    always_comb begin
        o_alucontrol = ALU_ADD;
        case (i_aluop)
            ALUOP_ADD:   o_alucontrol = ALU_ADD;
            ALUOP_SUB:   o_alucontrol = ALU_SUB;
            ALUOP_FUNCT: o_alucontrol = w_funct_ctl;
            default:     o_alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS control FSM; MC_STATE_TMR_EN selects triplicated state
module mc_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       instret,
    output logic       illegal,
    output logic       state_err
);

    state_t     w_state;
    state_t     w_next;
    logic [1:0] w_aluop;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_memwrite;
    logic       w_funct_legal;
    logic       w_illegal_now;
    logic       r_illegal;

`ifdef MC_STATE_TMR_EN
    state_t r_state_a;
    state_t r_state_b;
    state_t r_state_c;

    // All three copies reload the voted next state, scrubbing any single upset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_a <= S_FETCH;
            r_state_b <= S_FETCH;
            r_state_c <= S_FETCH;
        end else begin
            r_state_a <= w_next;
            r_state_b <= w_next;
            r_state_c <= w_next;
        end
    end

    assign w_state   = state_t'((r_state_a & r_state_b) | (r_state_a & r_state_c) |
                                (r_state_b & r_state_c));
    assign state_err = (r_state_a != r_state_b) || (r_state_a != r_state_c);
`else
    state_t r_state;

    // Single state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    assign w_state   = r_state;
    assign state_err = 1'b0;
`endif

    // Next-state sequencing through the instruction steps
    always_comb begin
        w_next = S_FETCH;
        case (w_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = S_MEMWB;
            S_RTYPEEX: w_next = S_RTYPEWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            default:   w_next = S_FETCH;
        endcase
    end

    // Moore decode of datapath controls; everything not named is 0
    always_comb begin
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        w_aluop    = ALUOP_ADD;
        alusrca    = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        instret    = 1'b0;
        case (w_state)
            S_FETCH: begin
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                alusrcb   = 2'b01;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
                instret    = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                w_memwrite = 1'b1;
                instret    = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                w_aluop = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                regdst     = 1'b1;
                w_regwrite = w_funct_legal;
                instret    = w_funct_legal;
            end
            S_BEQEX: begin
                alusrca  = 1'b1;
                w_aluop  = ALUOP_SUB;
                pcsrc    = 2'b01;
                w_branch = 1'b1;
                instret  = 1'b1;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
                instret    = 1'b1;
            end
            S_JEX: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
                instret   = 1'b1;
            end
            default: ;
        endcase
    end

    mc_aludec u_aludec (
        .i_aluop       (w_aluop),
        .i_funct       (funct),
        .o_alucontrol  (alucontrol),
        .o_funct_legal (w_funct_legal)
    );

    // Write strobes are gated by reset so an abandoned instruction cannot commit anything
    assign pcen     = (w_pcwrite | (w_branch & zero)) & ~reset;
    assign irwrite  = w_irwrite  & ~reset;
    assign regwrite = w_regwrite & ~reset;
    assign memwrite = w_memwrite & ~reset;

    assign w_illegal_now = ((w_state == S_DECODE) && !op_known(op)) ||
                           ((w_state == S_RTYPEEX) && !w_funct_legal);

    // Sticky illegal-instruction flag, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              r_illegal <= 1'b0;
        else if (w_illegal_now) r_illegal <= 1'b1;
    end

    assign illegal = r_illegal | w_illegal_now;

endmodule
